// File: rtl/demorgan_sweep_ctrl.sv
// Exhaustive, cycle-exact sweep controller for a 3-input De Morgan datapath.
// Optional build macro: DEMORGAN_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module demorgan_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            o1,
  input  logic            o2,
  input  logic            o3,
  input  logic            o4,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [1:0]      first_fail_which,
  output logic            first_fail_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0] WLAST = WW'(SETTLE - 1);

  logic [1:0]    state;
  logic [WW-1:0] wcnt;
  logic [1:0]    mism;
  logic [N_IN:0] err_next;
  logic          finish;

  always_comb begin
    mism     = {o3 ^ o4, o1 ^ o2};
    err_next = err_count + {{N_IN{1'b0}}, |mism};
`ifdef DEMORGAN_STOP_ON_FAIL_EN
    finish   = (&vec_out) | (|mism);
`else
    finish   = &vec_out;
`endif
  end

  assign busy = (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      wcnt             <= '0;
      vec_out          <= '0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_which <= '0;
      first_fail_valid <= 1'b0;
    end else if (abort) begin
      // Partial error statistics survive an abort; only the sweep itself is dropped.
      if (state != S_IDLE) begin
        state   <= S_IDLE;
        wcnt    <= '0;
        vec_out <= '0;
        pass    <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_WAIT;
            wcnt             <= '0;
            vec_out          <= '0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_which <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wcnt == WLAST) state <= S_CHECK;
          else               wcnt  <= wcnt + WW'(1);
        end
        S_CHECK: begin
          if (|mism) begin
            err_count <= err_next;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec_out;
              first_fail_which <= mism;
              first_fail_valid <= 1'b1;
            end
          end
          // pass must reflect this vector's result, so it uses the look-ahead count.
          if (finish) begin
            state <= S_DONE;
            pass  <= (err_next == '0);
          end else begin
            state   <= S_WAIT;
            wcnt    <= '0;
            vec_out <= vec_out + N_IN'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driven by a
// behavioural datapath with per-vector fault masks and pre-settle glitches.
module tb_demorgan_sweep_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort;
  always #5 clk = ~clk;

  logic [1:0]  mask [8];
  logic        glitch_en;
  int unsigned cyc = 0;
  int unsigned base = 0;
  int passed = 0;
  int total  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] vec   [2];
  logic [3:0] o     [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [3:0] err   [2];
  logic [2:0] ffv   [2];
  logic [1:0] ffw   [2];
  logic       ffval [2];

  // Ideal De Morgan outputs, with mask bits flipping o2/o4 and a glitch flipping both.
  function automatic logic [3:0] dp(input logic [2:0] v, input logic [1:0] m, input logic g);
    logic a, b, c;
    logic [3:0] r;
    {c, b, a} = v;
    r[0] = ~(a | b | c);
    r[1] = (~a & ~b & ~c) ^ m[0] ^ g;
    r[2] = ~(a & b & c);
    r[3] = (~a | ~b | ~c) ^ m[1] ^ g;
    return r;
  endfunction

  assign o[0] = dp(vec[0], mask[vec[0]], glitch_en && (((cyc - base) % 2) != 1));
  assign o[1] = dp(vec[1], mask[vec[1]], glitch_en && (((cyc - base) % 4) != 3));

  demorgan_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec[0]),
    .o1(o[0][0]), .o2(o[0][1]), .o3(o[0][2]), .o4(o[0][3]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]),
    .first_fail_vec(ffv[0]), .first_fail_which(ffw[0]), .first_fail_valid(ffval[0]));

  demorgan_sweep_ctrl #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec[1]),
    .o1(o[1][0]), .o2(o[1][1]), .o3(o[1][2]), .o4(o[1][3]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
    .first_fail_vec(ffv[1]), .first_fail_which(ffw[1]), .first_fail_valid(ffval[1]));

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({vec[d], busy[d], done[d], pass[d], err[d], ffv[d], ffw[d], ffval[d]} !== 15'h0)
        $display("FAIL reset_state dut%0d: got %0h expected 0", d,
                 {vec[d], busy[d], done[d], pass[d], err[d], ffv[d], ffw[d], ffval[d]});
      else passed++;
    end
    rst = 1'b0;
  endtask

  // Full sweep on both instances, cycle by cycle against the reference schedule.
  task automatic test_sweep(input string name, input bit mid_start, input bit glit);
    int f = -1;
    int nf = 0;
    bit stop;
    int unsigned sp [2];
    int unsigned last [2];
    int unsigned dn [2];
    int unsigned errx [2];
    logic [10:0] fin_exp [2];
    logic [2:0]  vexp;
`ifdef DEMORGAN_STOP_ON_FAIL_EN
    stop = 1'b1;
`else
    stop = 1'b0;
`endif
    for (int v = 0; v < 8; v++)
      if (mask[v] != 2'b00) begin
        nf++;
        if (f < 0) f = v;
      end
    for (int d = 0; d < 2; d++) begin
      sp[d]   = (d == 0) ? 2 : 4;
      last[d] = (stop && f >= 0) ? f : 7;
      dn[d]   = (last[d] + 1) * sp[d];
      errx[d] = (stop && f >= 0) ? 1 : nf;
      fin_exp[d] = {errx[d] == 0, 4'(errx[d]), f >= 0,
                    (f >= 0) ? 3'(f) : 3'd0, (f >= 0) ? mask[f] : 2'b00};
    end
    glitch_en = glit;
    @(negedge clk);
    base  = cyc + 1;
    start = 1'b1;
    for (int unsigned n = 0; n <= dn[1] + 1; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (mid_start && n == 6) start = 1'b1;
      if (mid_start && n == 7) start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (n <= dn[d] + 1) begin
          vexp = (n < dn[d]) ? 3'(n / sp[d]) : 3'(last[d]);
          total++;
          if (vec[d] !== vexp)
            $display("FAIL %s vec dut%0d n=%0d: got %0d expected %0d", name, d, n, vec[d], vexp);
          else passed++;
          total++;
          if ({busy[d], done[d]} !== {n < dn[d], n == dn[d]})
            $display("FAIL %s busy_done dut%0d n=%0d: got %b expected %b", name, d, n,
                     {busy[d], done[d]}, {n < dn[d], n == dn[d]});
          else passed++;
          if (n == 0) begin
            total++;
            if ({pass[d], err[d], ffval[d]} !== 6'h0)
              $display("FAIL %s cleared dut%0d: got %0h expected 0", name, d,
                       {pass[d], err[d], ffval[d]});
            else passed++;
          end
          if (n == dn[d]) begin
            total++;
            if ({pass[d], err[d], ffval[d], ffv[d], ffw[d]} !== fin_exp[d])
              $display("FAIL %s result dut%0d: got pass/err/val/vec/which %0h expected %0h",
                       name, d, {pass[d], err[d], ffval[d], ffv[d], ffw[d]}, fin_exp[d]);
            else passed++;
          end
        end
      end
    end
    glitch_en = 1'b0;
  endtask

  task automatic test_clean();
    for (int v = 0; v < 8; v++) mask[v] = 2'b00;
    test_sweep("clean", 1'b0, 1'b1);
  endtask

  task automatic test_o4_stuck();
    for (int v = 0; v < 8; v++) mask[v] = (v < 7) ? 2'b10 : 2'b00;
    test_sweep("o4_stuck0", 1'b0, 1'b0);
  endtask

  task automatic test_mid_start();
    for (int v = 0; v < 8; v++) mask[v] = 2'($urandom_range(0, 3));
    test_sweep("mid_start", 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 8; v++) mask[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      test_sweep("random", 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_abort();
    bit stop;
    int unsigned kp, nf, f;
    logic [9:0] pexp;
`ifdef DEMORGAN_STOP_ON_FAIL_EN
    stop = 1'b1;
`else
    stop = 1'b0;
`endif
    for (int v = 0; v < 8; v++) mask[v] = 2'($urandom_range(0, 3));
    if (stop) begin mask[0] = 2'b00; mask[1] = 2'b00; end
    else      mask[0] = 2'b01;
    @(negedge clk);
    base  = cyc + 1;
    start = 1'b1;
    for (int unsigned n = 0; n <= 5; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 4) abort = 1'b1;
    end
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      kp = 4 / ((d == 0) ? 2 : 4);
      nf = 0; f = 8;
      for (int unsigned v = 0; v < kp; v++)
        if (mask[v] != 2'b00) begin
          nf++;
          if (f == 8) f = v;
        end
      pexp = {4'(nf), f != 8, (f != 8) ? 3'(f) : 3'd0, (f != 8) ? mask[f] : 2'b00};
      total++;
      if ({busy[d], done[d], pass[d], vec[d]} !== 6'h0)
        $display("FAIL abort_idle dut%0d: got busy/done/pass/vec %0h expected 0", d,
                 {busy[d], done[d], pass[d], vec[d]});
      else passed++;
      total++;
      if ({err[d], ffval[d], ffv[d], ffw[d]} !== pexp)
        $display("FAIL abort_partial dut%0d: got %0h expected %0h", d,
                 {err[d], ffval[d], ffv[d], ffw[d]}, pexp);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({busy[d], done[d]} !== 2'b00)
          $display("FAIL abort_no_done dut%0d: got %b expected 00", d, {busy[d], done[d]});
        else passed++;
      end
    end
    test_sweep("after_abort", 1'b0, 1'b0);
  endtask

  task automatic test_abort_start_idle();
    logic [2:0] vhold [2];
    @(negedge clk);
    vhold[0] = vec[0]; vhold[1] = vec[1];
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy[d], done[d], vec[d]} !== {2'b00, vhold[d]})
        $display("FAIL abort_start_idle dut%0d: got %0h expected %0h", d,
                 {busy[d], done[d], vec[d]}, {2'b00, vhold[d]});
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    for (int v = 0; v < 8; v++) mask[v] = 2'b11;
    @(negedge clk);
    base  = cyc + 1;
    start = 1'b1;
    for (int unsigned n = 0; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 8) rst = 1'b1;
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({vec[d], busy[d], done[d], pass[d], err[d], ffv[d], ffw[d], ffval[d]} !== 15'h0)
        $display("FAIL reset_mid dut%0d: got %0h expected 0", d,
                 {vec[d], busy[d], done[d], pass[d], err[d], ffv[d], ffw[d], ffval[d]});
      else passed++;
    end
    for (int v = 0; v < 8; v++) mask[v] = 2'b00;
    test_sweep("after_reset", 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; glitch_en = 1'b0;
    for (int v = 0; v < 8; v++) mask[v] = 2'b00;
    test_reset();
    test_clean();
    test_o4_stuck();
    test_mid_start();
    test_random();
    test_abort();
    test_abort_start_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
